// File: rtl/bitstream_stream_loader.sv
// bitstream_stream_loader: packs a byte stream MSB-first into 32-bit words and writes
// them to the fabric self-configuration port with fixed setup and gap spacing.
module bitstream_stream_loader #(
    parameter int NUM_BYTES    = 21140,
    parameter int SETUP_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] SelfWriteData,
    output logic        SelfWriteStrobe,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_count
);
    localparam int BW = $clog2(NUM_BYTES + 1);
    typedef enum logic [2:0] {IDLE, COLLECT, PAD, SETUP, STROBE, GAP, DONE} state_t;
    state_t state, state_nx;
    logic [BW-1:0] byte_cnt;
    logic [1:0] lane;
    logic [3:0] tmr;
    logic [23:0] word;
    logic [7:0] shin;
    logic shift, last_byte, fin, launch;
    assign shift = (state == COLLECT && byte_valid) || state == PAD;
    assign shin = state == PAD ? 8'h00 : byte_data;
    assign last_byte = byte_cnt == BW'(NUM_BYTES - 1);
    assign fin = byte_cnt == BW'(NUM_BYTES);
    assign launch = (state == IDLE || state == DONE) && start;
    assign byte_ready = state == COLLECT;
    assign SelfWriteStrobe = state == STROBE;
    assign busy = state == COLLECT || state == PAD || state == SETUP || state == STROBE || state == GAP;
    assign done = state == DONE;
    always_ff @(posedge CLK)
        state <= rst ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? COLLECT : state;
            COLLECT: if (byte_valid) state_nx = lane == 2'd3 ? SETUP : last_byte ? PAD : COLLECT;
            PAD: state_nx = lane == 2'd3 ? SETUP : PAD;
            SETUP: state_nx = tmr == 4'(SETUP_CYCLES - 1) ? STROBE : SETUP;
            STROBE: state_nx = GAP_CYCLES != 0 ? GAP : fin ? DONE : COLLECT;
            GAP: state_nx = tmr != 4'(GAP_CYCLES - 1) ? GAP : fin ? DONE : COLLECT;
            default: state_nx = IDLE;
        endcase
    end
    // tmr restarts on every state change, so it counts cycles spent in SETUP/GAP
    always_ff @(posedge CLK) begin
        if (rst) begin
            byte_cnt <= '0;
            lane <= '0;
            tmr <= '0;
            word <= '0;
            SelfWriteData <= '0;
            word_count <= '0;
        end else begin
            tmr <= state_nx != state ? 4'd0 : tmr + 4'd1;
            if (launch) begin
                byte_cnt <= '0;
                lane <= '0;
                word_count <= '0;
            end
            if (state == COLLECT && byte_valid) byte_cnt <= byte_cnt + BW'(1);
            if (shift) begin
                word <= {word[15:0], shin};
                lane <= lane + 2'd1;
            end
            if (shift && lane == 2'd3) SelfWriteData <= {word, shin};
            if (state == STROBE && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_bitstream_stream_loader.sv
// tb_bitstream_stream_loader: three loaders (4, 6 and 21140 bytes) checked against a
// timeline model of accepted bytes, padded words and strobe/gap spacing.
module tb_bitstream_stream_loader;
    localparam int SU = 2;
    localparam int GP = 2;
    logic CLK = 0;
    always #5 CLK = ~CLK;
    logic rst;
    logic st [3];
    logic bv [3];
    logic [7:0] bd [3];
    logic rdy [3];
    logic [31:0] swd [3];
    logic sws [3];
    logic bsy [3];
    logic dn [3];
    logic [15:0] wc [3];
    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gd
        localparam int NB = g == 0 ? 4 : g == 1 ? 6 : 21140;
        bitstream_stream_loader #(.NUM_BYTES(NB)) dut (
            .CLK(CLK), .rst(rst), .start(st[g]), .byte_data(bd[g]), .byte_valid(bv[g]),
            .byte_ready(rdy[g]), .SelfWriteData(swd[g]), .SelfWriteStrobe(sws[g]),
            .busy(bsy[g]), .done(dn[g]), .word_count(wc[g])
        );
        // ph: 0 idle, 1 collecting, 2 writing a word, 3 done
        int ph = 0, nacc = 0, cur = 0, mwc = 0, t = 0, s_at = -1, r_at = -1, ns = 0;
        bit armed = 0;
        logic [31:0] wacc = 0, wout = 0;
        logic [31:0] ow [8];
        initial forever begin
            @(negedge CLK);
            t++;
            if (armed) begin
                if (errors < 100)
                    check($sformatf("status[%0d] t=%0d", g, t), {13'd0, rdy[g], bsy[g], dn[g], wc[g]},
                          {13'd0, ph == 1, ph == 1 || ph == 2, ph == 3, 16'(mwc)});
                if (sws[g] || (ph == 2 && t == s_at)) begin
                    check($sformatf("strobe[%0d] t=%0d", g, t), {31'd0, sws[g]}, {31'd0, ph == 2 && t == s_at});
                    check($sformatf("word[%0d] t=%0d", g, t), swd[g], wout);
                end
            end
            if (sws[g]) begin
                if (ns < 8) ow[ns] = swd[g];
                ns++;
            end
            if (rst) begin
                ph = 0; nacc = 0; cur = 0; mwc = 0; wacc = 0; wout = 0; armed = 1;
            end else if (ph == 0 || ph == 3) begin
                if (st[g]) begin
                    ph = 1; nacc = 0; cur = 0; mwc = 0;
                end
            end else if (ph == 1) begin
                if (bv[g]) begin
                    wacc = {wacc[23:0], bd[g]};
                    cur++;
                    nacc++;
                    if (cur == 4 || nacc == NB) begin
                        wout = wacc << (8 * (4 - cur));
                        s_at = t + (4 - cur) + SU + 1;
                        r_at = s_at + GP + 1;
                        ph = 2;
                        cur = 0;
                    end
                end
            end else begin
                if (t == s_at && mwc < 65535) mwc++;
                if (t + 1 == r_at) ph = nacc == NB ? 3 : 1;
            end
        end
    end

    task automatic pulse_start(input int d);
        @(posedge CLK);
        #1 st[d] = 1;
        @(posedge CLK);
        #1 st[d] = 0;
    endtask

    task automatic send(input int d, input logic [7:0] b, input int stall);
        int n = 0;
        bit acc = 0;
        repeat (stall) begin
            @(posedge CLK);
            #1;
        end
        bv[d] = 1;
        bd[d] = b;
        while (!acc && n < 64) begin
            @(negedge CLK);
            acc = rdy[d];
            @(posedge CLK);
            #1;
            n++;
        end
        bv[d] = 0;
        if (!acc) check($sformatf("accept_timeout[%0d]", d), 0, 1);
    endtask

    task automatic wait_done(input int d, input int lim);
        int n = 0;
        while (!dn[d] && n < lim) begin
            @(negedge CLK);
            n++;
        end
        check($sformatf("done[%0d]", d), {31'd0, dn[d]}, 1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int base;
        rst = 1;
        for (int d = 0; d < 3; d++) begin
            st[d] = 0; bv[d] = 1; bd[d] = 8'hA5;
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ctl[%0d]", d), {12'd0, rdy[d], sws[d], bsy[d], dn[d], wc[d]}, 0);
            check($sformatf("rst_data[%0d]", d), swd[d], 0);
        end
        @(posedge CLK);
        #1 rst = 0;
        for (int d = 0; d < 3; d++) bv[d] = 0;
        pulse_start(0);
        send(0, 8'hFA, 0); send(0, 8'hB0, 0); send(0, 8'hFA, 0); send(0, 8'hB1, 0);
        wait_done(0, 50);
        check("t2_word", gd[0].ow[0], 32'hFAB0FAB1);
        check("t2_strobes", gd[0].ns, 1);
        check("t2_wc", {16'd0, wc[0]}, 1);
        pulse_start(1);
        for (int i = 0; i < 6; i++) send(1, 8'h11 + 8'(i), $urandom_range(1));
        wait_done(1, 100);
        check("t4_word0", gd[1].ow[0], 32'h11121314);
        check("t4_word1", gd[1].ow[1], 32'h15160000);
        check("t4_wc", {16'd0, wc[1]}, 2);
        pulse_start(1);
        send(1, 8'h21, 0);
        pulse_start(1);
        for (int i = 1; i < 6; i++) send(1, 8'h21 + 8'(i), 0);
        wait_done(1, 100);
        check("t6_word0", gd[1].ow[2], 32'h21222324);
        check("t6_word1", gd[1].ow[3], 32'h25260000);
        check("t6_strobes", gd[1].ns, 4);
        check("t6_wc", {16'd0, wc[1]}, 2);
        pulse_start(2);
        for (int i = 0; i < 8; i++) send(2, 8'(i), 1);
        repeat (12) @(posedge CLK);
        #1;
        check("t3_word0", gd[2].ow[0], 32'h00010203);
        check("t3_word1", gd[2].ow[1], 32'h04050607);
        check("t3_strobes", gd[2].ns, 2);
        check("t3_wc", {16'd0, wc[2]}, 2);
        for (int i = 8; i < 12; i++) send(2, 8'(i), 0);
        rst = 1;
        @(posedge CLK);
        #1 rst = 0;
        repeat (6) @(posedge CLK);
        #1;
        check("t5_abort_strobes", gd[2].ns, 2);
        check("t5_abort_wc", {16'd0, wc[2]}, 0);
        check("t5_abort_busy", {31'd0, bsy[2]}, 0);
        base = gd[2].ns;
        pulse_start(2);
        for (int i = 0; i < 21140; i++) send(2, 8'($urandom), $urandom_range(7) == 0);
        wait_done(2, 100);
        check("t5_strobes", gd[2].ns - base, 5285);
        check("t5_wc", {16'd0, wc[2]}, 5285);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
